alu_cmd_ctrl: RTL and testbench

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

---
 rtl/alu_cmd_ctrl_if.sv | 29 ++
 rtl/alu_cmd_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_ctrl_if.sv
// Byte-stream, ALU and transmitter signals of the ALU command controller.
// master: the controller itself; slave: the byte source, ALU and transmitter around it.
interface alu_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_VALID;
  logic [DATA_WIDTH-1:0] ALU_A;
  logic [DATA_WIDTH-1:0] ALU_B;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  ALU_EN;
  logic [DATA_WIDTH-1:0] ALU_OUT;
  logic                  ALU_OUT_VALID;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_VALID;
  logic                  TX_BUSY;
  logic                  BUSY;

  modport master (
    input  RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY
  );

  modport slave (
    output RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID, BUSY
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Command-frame controller: collects 0xCC,A,B,FUN from a byte stream, drives the ALU and returns one response byte.
// Define ALU_CMD_TIMEOUT_EN to abort a stalled ALU with response 0xEE after TIMEOUT cycles in WAIT_RES.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input logic            CLK,
  input logic            RST,
  alu_cmd_ctrl_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] CMD_START   = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] RSP_BAD_FUN = DATA_WIDTH'(8'hEF);

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_FUN,
    EXEC,
    WAIT_RES,
    SEND
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_nxt;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_nxt;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_nxt;
  logic [DATA_WIDTH-1:0] resp_q, resp_nxt;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_nxt;
  logic                  alu_en_q;
  logic                  busy_q;
  logic                  fun_hi_zero;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam logic [DATA_WIDTH-1:0] RSP_TIMEOUT = DATA_WIDTH'(8'hEE);
  localparam int                    CNT_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_nxt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Function bytes with any bit set above the function field are rejected.
  assign fun_hi_zero = (bus.RX_DATA[DATA_WIDTH-1:FUN_WIDTH] == '0);

  always_comb begin
    state_nxt   = state;
    alu_a_nxt   = alu_a_q;
    alu_b_nxt   = alu_b_q;
    alu_fun_nxt = alu_fun_q;
    resp_nxt    = resp_q;
    tx_data_nxt = tx_data_q;
`ifdef ALU_CMD_TIMEOUT_EN
    tmo_cnt_nxt = tmo_cnt_q;
`endif

    case (state)
      IDLE: begin
        if (bus.RX_VALID && (bus.RX_DATA == CMD_START)) state_nxt = GET_A;
      end
      GET_A: begin
        if (bus.RX_VALID) begin
          alu_a_nxt = bus.RX_DATA;
          state_nxt = GET_B;
        end
      end
      GET_B: begin
        if (bus.RX_VALID) begin
          alu_b_nxt = bus.RX_DATA;
          state_nxt = GET_FUN;
        end
      end
      GET_FUN: begin
        if (bus.RX_VALID) begin
          if (fun_hi_zero) begin
            alu_fun_nxt = bus.RX_DATA[FUN_WIDTH-1:0];
            state_nxt   = EXEC;
          end else begin
            resp_nxt  = RSP_BAD_FUN;
            state_nxt = SEND;
          end
        end
      end
      EXEC: begin
        // ALU_OUT_VALID is not looked at here, so a result coincident with ALU_EN is dropped.
        state_nxt = WAIT_RES;
`ifdef ALU_CMD_TIMEOUT_EN
        tmo_cnt_nxt = '0;
`endif
      end
      WAIT_RES: begin
        if (bus.ALU_OUT_VALID) begin
          resp_nxt  = bus.ALU_OUT;
          state_nxt = SEND;
        end
`ifdef ALU_CMD_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_LAST) begin
          resp_nxt  = RSP_TIMEOUT;
          state_nxt = SEND;
        end else begin
          tmo_cnt_nxt = tmo_cnt_q + 1'b1;
        end
`endif
      end
      SEND: begin
        if (!bus.TX_BUSY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // TX_DATA is set up on entry to SEND so it is already valid when TX_VALID rises.
    if ((state_nxt == SEND) && (state != SEND)) tx_data_nxt = resp_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_fun_q <= '0;
      resp_q    <= '0;
      tx_data_q <= '0;
      alu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ALU_CMD_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state     <= state_nxt;
      alu_a_q   <= alu_a_nxt;
      alu_b_q   <= alu_b_nxt;
      alu_fun_q <= alu_fun_nxt;
      resp_q    <= resp_nxt;
      tx_data_q <= tx_data_nxt;
      alu_en_q  <= (state_nxt == EXEC);
      busy_q    <= (state_nxt != IDLE);
`ifdef ALU_CMD_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_nxt;
`endif
    end
  end

  assign bus.ALU_A    = alu_a_q;
  assign bus.ALU_B    = alu_b_q;
  assign bus.ALU_FUN  = alu_fun_q;
  assign bus.ALU_EN   = alu_en_q;
  assign bus.TX_DATA  = tx_data_q;
  assign bus.BUSY     = busy_q;
  // The strobe follows TX_BUSY directly so it fires in the first free cycle.
  assign bus.TX_VALID = (state == SEND) && !bus.TX_BUSY;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed testbench for alu_cmd_ctrl: frames, rejected bytes, back-pressure, timeout and reset.
// Covers both builds of ALU_CMD_TIMEOUT_EN.
module tb_alu_cmd_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   en_pulses = 0;
  int   tx_pulses = 0;
  logic [7:0] last_tx = 8'h00;

  alu_cmd_ctrl_if #(.DATA_WIDTH(8), .FUN_WIDTH(4)) bus ();

  alu_cmd_ctrl #(.DATA_WIDTH(8), .FUN_WIDTH(4), .TIMEOUT(15)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.ALU_EN === 1'b1) en_pulses <= en_pulses + 1;
    if (bus.TX_VALID === 1'b1) begin
      tx_pulses <= tx_pulses + 1;
      last_tx   <= bus.TX_DATA;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_DATA  = b;
    bus.RX_VALID = 1'b1;
    cyc();
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.ALU_A !== 8'h00) begin n_fail++; $display("FAIL reset_alu_a: got %h expected 00", bus.ALU_A); end
    n_checks++; if (bus.ALU_B !== 8'h00) begin n_fail++; $display("FAIL reset_alu_b: got %h expected 00", bus.ALU_B); end
    n_checks++; if (bus.ALU_FUN !== 4'h0) begin n_fail++; $display("FAIL reset_alu_fun: got %h expected 0", bus.ALU_FUN); end
    n_checks++; if (bus.ALU_EN !== 1'b0) begin n_fail++; $display("FAIL reset_alu_en: got %b expected 0", bus.ALU_EN); end
    n_checks++; if (bus.TX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", bus.TX_DATA); end
    n_checks++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", bus.TX_VALID); end
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_basic_frame();
    int en0 = en_pulses;
    int tx0 = tx_pulses;
    send_byte(8'hCC);
    n_checks++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.BUSY); end
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h00);
    n_checks++; if (bus.ALU_EN !== 1'b1) begin n_fail++; $display("FAIL basic_alu_en_latency: got %b expected 1", bus.ALU_EN); end
    n_checks++; if (bus.ALU_A !== 8'h05) begin n_fail++; $display("FAIL basic_alu_a: got %h expected 05", bus.ALU_A); end
    n_checks++; if (bus.ALU_B !== 8'h03) begin n_fail++; $display("FAIL basic_alu_b: got %h expected 03", bus.ALU_B); end
    n_checks++; if (bus.ALU_FUN !== 4'h0) begin n_fail++; $display("FAIL basic_alu_fun: got %h expected 0", bus.ALU_FUN); end
    cyc();
    n_checks++; if (bus.ALU_EN !== 1'b0) begin n_fail++; $display("FAIL basic_alu_en_single: got %b expected 0", bus.ALU_EN); end
    bus.ALU_OUT       = 8'h08;
    bus.ALU_OUT_VALID = 1'b1;
    cyc();
    bus.ALU_OUT_VALID = 1'b0;
    n_checks++; if (bus.TX_VALID !== 1'b1) begin n_fail++; $display("FAIL basic_tx_valid: got %b expected 1", bus.TX_VALID); end
    n_checks++; if (bus.TX_DATA !== 8'h08) begin n_fail++; $display("FAIL basic_tx_data: got %h expected 08", bus.TX_DATA); end
    cyc();
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle: got %b expected 0", bus.BUSY); end
    repeat (3) cyc();
    n_checks++; if (en_pulses - en0 !== 1) begin n_fail++; $display("FAIL basic_en_count: got %0d expected 1", en_pulses - en0); end
    n_checks++; if (tx_pulses - tx0 !== 1) begin n_fail++; $display("FAIL basic_tx_count: got %0d expected 1", tx_pulses - tx0); end
  endtask

  task automatic test_ignore_bytes();
    int en0 = en_pulses;
    int tx0 = tx_pulses;
    send_byte(8'h12);
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL ignore_idle_busy: got %b expected 0", bus.BUSY); end
    send_byte(8'hCC);
    send_byte(8'h21);
    send_byte(8'h07);
    send_byte(8'h09);
    n_checks++; if (bus.ALU_FUN !== 4'h9) begin n_fail++; $display("FAIL ignore_alu_fun: got %h expected 9", bus.ALU_FUN); end
    // Result coincident with ALU_EN and an RX byte in EXEC must both be dropped.
    bus.ALU_OUT       = 8'h77;
    bus.ALU_OUT_VALID = 1'b1;
    bus.RX_DATA       = 8'hCC;
    bus.RX_VALID      = 1'b1;
    cyc();
    bus.ALU_OUT_VALID = 1'b0;
    bus.RX_DATA       = 8'h44;
    cyc();
    bus.RX_VALID      = 1'b0;
    bus.RX_DATA       = 8'h00;
    n_checks++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL ignore_wait_busy: got %b expected 1", bus.BUSY); end
    n_checks++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL ignore_wait_tx_valid: got %b expected 0", bus.TX_VALID); end
    n_checks++; if (bus.ALU_A !== 8'h21) begin n_fail++; $display("FAIL ignore_alu_a_held: got %h expected 21", bus.ALU_A); end
    bus.ALU_OUT       = 8'h5A;
    bus.ALU_OUT_VALID = 1'b1;
    cyc();
    bus.ALU_OUT_VALID = 1'b0;
    n_checks++; if (bus.TX_DATA !== 8'h5A) begin n_fail++; $display("FAIL ignore_tx_data: got %h expected 5a", bus.TX_DATA); end
    repeat (3) cyc();
    n_checks++; if (en_pulses - en0 !== 1) begin n_fail++; $display("FAIL ignore_en_count: got %0d expected 1", en_pulses - en0); end
    n_checks++; if (tx_pulses - tx0 !== 1) begin n_fail++; $display("FAIL ignore_tx_count: got %0d expected 1", tx_pulses - tx0); end
  endtask

  task automatic test_bad_fun();
    int en0 = en_pulses;
    int tx0 = tx_pulses;
    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h31);
    n_checks++; if (bus.ALU_EN !== 1'b0) begin n_fail++; $display("FAIL badfun_alu_en: got %b expected 0", bus.ALU_EN); end
    n_checks++; if (bus.TX_VALID !== 1'b1) begin n_fail++; $display("FAIL badfun_tx_valid: got %b expected 1", bus.TX_VALID); end
    n_checks++; if (bus.TX_DATA !== 8'hEF) begin n_fail++; $display("FAIL badfun_tx_data: got %h expected ef", bus.TX_DATA); end
    n_checks++; if (bus.ALU_FUN !== 4'h9) begin n_fail++; $display("FAIL badfun_fun_held: got %h expected 9", bus.ALU_FUN); end
    repeat (3) cyc();
    n_checks++; if (en_pulses - en0 !== 0) begin n_fail++; $display("FAIL badfun_en_count: got %0d expected 0", en_pulses - en0); end
    n_checks++; if (tx_pulses - tx0 !== 1) begin n_fail++; $display("FAIL badfun_tx_count: got %0d expected 1", tx_pulses - tx0); end
  endtask

  task automatic test_tx_busy();
    int tx0 = tx_pulses;
    int held_bad = 0;
    bus.TX_BUSY = 1'b1;
    send_byte(8'hCC);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h02);
    cyc();
    bus.ALU_OUT       = 8'h30;
    bus.ALU_OUT_VALID = 1'b1;
    cyc();
    bus.ALU_OUT_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.TX_VALID !== 1'b0) held_bad++;
      cyc();
    end
    n_checks++; if (held_bad !== 0) begin n_fail++; $display("FAIL txbusy_held_low: got %0d strobes expected 0", held_bad); end
    bus.TX_BUSY = 1'b0;
    #1;
    n_checks++; if (bus.TX_VALID !== 1'b1) begin n_fail++; $display("FAIL txbusy_release_valid: got %b expected 1", bus.TX_VALID); end
    n_checks++; if (bus.TX_DATA !== 8'h30) begin n_fail++; $display("FAIL txbusy_tx_data: got %h expected 30", bus.TX_DATA); end
    cyc();
    n_checks++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL txbusy_single_pulse: got %b expected 0", bus.TX_VALID); end
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL txbusy_busy_idle: got %b expected 0", bus.BUSY); end
    n_checks++; if (tx_pulses - tx0 !== 1) begin n_fail++; $display("FAIL txbusy_tx_count: got %0d expected 1", tx_pulses - tx0); end
  endtask

  task automatic test_wait_res();
    int tx0 = tx_pulses;
    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h01);
    cyc();
`ifdef ALU_CMD_TIMEOUT_EN
    repeat (14) cyc();
    n_checks++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_before: got %b expected 1", bus.BUSY); end
    n_checks++; if (bus.TX_VALID !== 1'b0) begin n_fail++; $display("FAIL timeout_early_tx: got %b expected 0", bus.TX_VALID); end
    cyc();
    n_checks++; if (bus.TX_VALID !== 1'b1) begin n_fail++; $display("FAIL timeout_tx_valid: got %b expected 1", bus.TX_VALID); end
    n_checks++; if (bus.TX_DATA !== 8'hEE) begin n_fail++; $display("FAIL timeout_tx_data: got %h expected ee", bus.TX_DATA); end
    cyc();
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_after: got %b expected 0", bus.BUSY); end
    n_checks++; if (tx_pulses - tx0 !== 1) begin n_fail++; $display("FAIL timeout_tx_count: got %0d expected 1", tx_pulses - tx0); end
`else
    repeat (40) cyc();
    n_checks++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b expected 1", bus.BUSY); end
    n_checks++; if (tx_pulses - tx0 !== 0) begin n_fail++; $display("FAIL stall_tx_count: got %0d expected 0", tx_pulses - tx0); end
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL stall_recover_busy: got %b expected 0", bus.BUSY); end
`endif
  endtask

  task automatic test_reset_mid();
    int en0;
    int tx0 = tx_pulses;
    send_byte(8'hCC);
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h03);
    cyc();
    rst = 1'b0;
    #2;
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_busy: got %b expected 0", bus.BUSY); end
    n_checks++; if (bus.ALU_A !== 8'h00) begin n_fail++; $display("FAIL rstmid_async_alu_a: got %h expected 00", bus.ALU_A); end
    cyc();
    rst = 1'b1;
    cyc();
    bus.ALU_OUT       = 8'h55;
    bus.ALU_OUT_VALID = 1'b1;
    cyc();
    bus.ALU_OUT_VALID = 1'b0;
    repeat (3) cyc();
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.BUSY); end
    n_checks++; if (bus.ALU_B !== 8'h00) begin n_fail++; $display("FAIL rstmid_alu_b: got %h expected 00", bus.ALU_B); end
    n_checks++; if (bus.ALU_FUN !== 4'h0) begin n_fail++; $display("FAIL rstmid_alu_fun: got %h expected 0", bus.ALU_FUN); end
    n_checks++; if (bus.TX_DATA !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx_data: got %h expected 00", bus.TX_DATA); end
    n_checks++; if (tx_pulses - tx0 !== 0) begin n_fail++; $display("FAIL rstmid_tx_count: got %0d expected 0", tx_pulses - tx0); end
    // Reset between the A byte and the rest of the frame: the tail must not be taken as a frame.
    en0 = en_pulses;
    send_byte(8'hCC);
    send_byte(8'h44);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    send_byte(8'h55);
    send_byte(8'h00);
    repeat (3) cyc();
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rstframe_busy: got %b expected 0", bus.BUSY); end
    n_checks++; if (bus.ALU_A !== 8'h00) begin n_fail++; $display("FAIL rstframe_alu_a: got %h expected 00", bus.ALU_A); end
    n_checks++; if (en_pulses - en0 !== 0) begin n_fail++; $display("FAIL rstframe_en_count: got %0d expected 0", en_pulses - en0); end
  endtask

  task automatic test_back_to_back();
    int tx0 = tx_pulses;
    send_byte(8'hCC);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h01);
    cyc();
    bus.ALU_OUT       = 8'h07;
    bus.ALU_OUT_VALID = 1'b1;
    cyc();
    bus.ALU_OUT_VALID = 1'b0;
    n_checks++; if (bus.TX_DATA !== 8'h07) begin n_fail++; $display("FAIL b2b_first_tx_data: got %h expected 07", bus.TX_DATA); end
    cyc();
    n_checks++; if (bus.ALU_A !== 8'h03) begin n_fail++; $display("FAIL b2b_alu_a_held: got %h expected 03", bus.ALU_A); end
    send_byte(8'hCC);
    send_byte(8'h09);
    send_byte(8'h0A);
    send_byte(8'hF1);
    n_checks++; if (bus.ALU_A !== 8'h09) begin n_fail++; $display("FAIL b2b_alu_a: got %h expected 09", bus.ALU_A); end
    n_checks++; if (bus.ALU_B !== 8'h0A) begin n_fail++; $display("FAIL b2b_alu_b: got %h expected 0a", bus.ALU_B); end
    n_checks++; if (bus.ALU_FUN !== 4'h1) begin n_fail++; $display("FAIL b2b_fun_held: got %h expected 1", bus.ALU_FUN); end
    n_checks++; if (bus.TX_DATA !== 8'hEF) begin n_fail++; $display("FAIL b2b_second_tx_data: got %h expected ef", bus.TX_DATA); end
    repeat (2) cyc();
    n_checks++; if (tx_pulses - tx0 !== 2) begin n_fail++; $display("FAIL b2b_tx_count: got %0d expected 2", tx_pulses - tx0); end
    n_checks++; if (last_tx !== 8'hEF) begin n_fail++; $display("FAIL b2b_last_tx: got %h expected ef", last_tx); end
  endtask

  initial begin
    rst               = 1'b0;
    bus.RX_DATA       = 8'h00;
    bus.RX_VALID      = 1'b0;
    bus.ALU_OUT       = 8'h00;
    bus.ALU_OUT_VALID = 1'b0;
    bus.TX_BUSY       = 1'b0;
    test_reset();
    test_basic_frame();
    test_ignore_bytes();
    test_bad_fun();
    test_tx_busy();
    test_wait_res();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
